muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 29 ++
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_step.sv | 28 ++
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and FSM
// encodings, iteration count and small op-decode helpers.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   localparam int ITERS = 32;
   localparam int CNT_W = $clog2(ITERS);

   function automatic logic op_is_div(op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(op_e op);
      return !op[0];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request bus and HI/LO result bus of the multiply/divide unit.
interface muldiv_unit_if;
   import muldiv_unit_pkg::*;

   logic        start;
   op_e         op;
   logic [31:0] busAEx;
   logic [31:0] busBEx;
   logic        mthi;
   logic        mtlo;
   logic        busy;
   logic        done;
   logic        divZero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, busAEx, busBEx, mthi, mtlo,
      input  busy, done, divZero, hi, lo
   );

   modport slave (
      input  start, op, busAEx, busBEx, mthi, mtlo,
      output busy, done, divZero, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract
// divide on a 64-bit {upper, lower} accumulator.
module muldiv_step (
   input  logic        is_div,
   input  logic [63:0] acc_i,
   input  logic [31:0] opb_i,
   output logic [63:0] acc_o
);

   logic [32:0] add_sum;
   logic [32:0] rem_sh;
   logic        rem_ge;
   logic [31:0] rem_sub;

   always_comb begin
      // multiply: lower half holds the remaining multiplier bits, LSB first
      add_sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opb_i} : 33'd0);
      // divide: upper half is the partial remainder, lower half shifts in quotient bits
      rem_sh  = acc_i[63:31];
      rem_ge  = (rem_sh >= {1'b0, opb_i});
      rem_sub = rem_sh[31:0] - opb_i;
      if (is_div)
         acc_o = {(rem_ge ? rem_sub : rem_sh[31:0]), acc_i[30:0], rem_ge};
      else
         acc_o = {add_sum, acc_i[31:1]};
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32 RUN iterations on
// operand magnitudes followed by a FIX cycle that applies the result signs.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   op_e                op_q, op_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [63:0]        acc_q, acc_d;
   logic [31:0]        opb_q, opb_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;

   logic               in_sign_a, in_sign_b;
   logic [31:0]        mag_a, mag_b;
   logic [63:0]        step_acc;
   logic [63:0]        mul_prod;
   logic [31:0]        quot, rem;

   muldiv_step u_step (
      .is_div (op_is_div(op_q)),
      .acc_i  (acc_q),
      .opb_i  (opb_q),
      .acc_o  (step_acc)
   );

   always_comb begin
      in_sign_a  = op_is_signed(bus.op) & bus.busAEx[31];
      in_sign_b  = op_is_signed(bus.op) & bus.busBEx[31];
      mag_a      = in_sign_a ? -bus.busAEx : bus.busAEx;
      mag_b      = in_sign_b ? -bus.busBEx : bus.busBEx;
      // unsigned ops carry zero signs, so these are identity for them
      mul_prod   = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quot       = (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
      rem        = sign_a_q ? -acc_q[63:32] : acc_q[63:32];

      state_d    = state_q;
      count_d    = count_q;
      op_d       = op_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (op_is_div(bus.op) && (bus.busBEx == 32'd0)) begin
                  div_zero_d = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  div_zero_d = 1'b0;
                  op_d       = bus.op;
                  sign_a_d   = in_sign_a;
                  sign_b_d   = in_sign_b;
                  acc_d      = {32'd0, mag_a};
                  opb_d      = mag_b;
                  count_d    = '0;
                  state_d    = ST_RUN;
               end
            end else begin
               if (bus.mthi) hi_d = bus.busAEx;
               if (bus.mtlo) lo_d = bus.busAEx;
            end
         end
         ST_RUN: begin
            acc_d   = step_acc;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_LAST) state_d = ST_FIX;
         end
         ST_FIX: begin
            if (op_is_div(op_q)) begin
               hi_d = rem;
               lo_d = quot;
            end else begin
               hi_d = mul_prod[63:32];
               lo_d = mul_prod[31:0];
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         op_q       <= OP_MULT;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         acc_q      <= '0;
         opb_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         op_q       <= op_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.done    = done_q;
   assign bus.divZero = div_zero_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic model
// of HI/LO results, divide-by-zero flag and fixed 33-cycle latency.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk;
   logic reset;
   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_hi  = 32'd0;
   logic [31:0] exp_lo  = 32'd0;
   logic        exp_dz  = 1'b0;
   bit          exp_zero_path;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // HI/LO semantics from plain integer arithmetic (truncating division)
   function automatic void model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, sp, sq, sr;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      exp_zero_path = 1'b0;
      case (op)
         2'b00: begin sp = sa * sb; {exp_hi, exp_lo} = sp; exp_dz = 1'b0; end
         2'b01: begin up = {32'd0, a} * {32'd0, b}; {exp_hi, exp_lo} = up; exp_dz = 1'b0; end
         2'b10: begin
            if (b == 32'd0) begin exp_zero_path = 1'b1; exp_dz = 1'b1; end
            else begin
               sq = sa / sb;
               sr = sa % sb;
               exp_lo = sq[31:0];
               exp_hi = sr[31:0];
               exp_dz = 1'b0;
            end
         end
         default: begin
            if (b == 32'd0) begin exp_zero_path = 1'b1; exp_dz = 1'b1; end
            else begin exp_lo = a / b; exp_hi = a % b; exp_dz = 1'b0; end
         end
      endcase
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noisy, input bit mt_same);
      int n;
      model_op(op, a, b);
      bus.start  = 1'b1;
      bus.op     = op_e'(op);
      bus.busAEx = a;
      bus.busBEx = b;
      bus.mthi   = mt_same;
      bus.mtlo   = mt_same;
      tick();
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      if (exp_zero_path) begin
         chk("dz_done", bus.done, 1);
         chk("dz_busy", bus.busy, 0);
         chk("dz_flag", bus.divZero, exp_dz);
         chk("dz_hi", bus.hi, exp_hi);
         chk("dz_lo", bus.lo, exp_lo);
         tick();
         chk("dz_done_clr", bus.done, 0);
         chk("dz_busy2", bus.busy, 0);
      end else begin
         n = 0;
         while (bus.busy && n < 50) begin
            n++;
            if (bus.done) chk("early_done", bus.done, 0);
            if (noisy) begin
               bus.busAEx = $urandom;
               bus.busBEx = $urandom;
               bus.start  = 1'($urandom_range(0, 1));
               bus.mthi   = 1'($urandom_range(0, 1));
               bus.mtlo   = 1'($urandom_range(0, 1));
            end
            tick();
         end
         bus.start = 1'b0;
         bus.mthi  = 1'b0;
         bus.mtlo  = 1'b0;
         chk("busy_cycles", 64'(n), 64'd33);
         chk("done", bus.done, 1);
         chk("hi", bus.hi, exp_hi);
         chk("lo", bus.lo, exp_lo);
         chk("dz", bus.divZero, exp_dz);
         tick();
         chk("done_pulse", bus.done, 0);
         chk("hi_hold", bus.hi, exp_hi);
         chk("lo_hold", bus.lo, exp_lo);
      end
   endtask

   task automatic mt_write(input bit wh, input bit wl, input logic [31:0] v);
      bus.mthi   = wh;
      bus.mtlo   = wl;
      bus.busAEx = v;
      tick();
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      if (wh) exp_hi = v;
      if (wl) exp_lo = v;
      chk("mt_hi", bus.hi, exp_hi);
      chk("mt_lo", bus.lo, exp_lo);
      chk("mt_busy", bus.busy, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bus.start  = 1'b0;
      bus.op     = OP_MULT;
      bus.busAEx = 32'd0;
      bus.busBEx = 32'd0;
      bus.mthi   = 1'b0;
      bus.mtlo   = 1'b0;
      reset      = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_dz", bus.divZero, 0);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", bus.lo, 32'h0000_0001);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);
      chk("mult_neg_lo", bus.lo, 32'hFFFF_FFF1);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
      chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd100, 32'd0, 0, 0);
      chk("divu0_flag", bus.divZero, 1);
      run_op(2'b01, 32'd7, 32'd9, 0, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      chk("div_wrap_lo", bus.lo, 32'h8000_0000);
      chk("div_wrap_hi", bus.hi, 32'h0000_0000);
      run_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1, 0);
      mt_write(1, 1, 32'hA5A5_5A5A);
      run_op(2'b11, 32'hDEAD_BEEF, 32'd13, 0, 1);

      // reset in the 10th busy cycle aborts without a result
      bus.start  = 1'b1;
      bus.op     = OP_MULT;
      bus.busAEx = 32'd123;
      bus.busBEx = 32'd456;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("pre_rst_busy", bus.busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      exp_dz = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_hi", bus.hi, 0);
      chk("abort_lo", bus.lo, 0);
      mt_write(1, 0, 32'd5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_no_done", bus.done, 0);
      end

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 4) == 0)
            mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         else
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
